// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the exception controller.
// Source bit indices, priority slots, ExcCodes, vector offsets and FSM states.
package exc_pkg;
   typedef enum int unsigned {
      EXC_DIRTY, EXC_INST_MISS, EXC_DATA_MISS, EXC_INST_INVALID, EXC_DATA_INVALID,
      EXC_ILLEGAL_INST, EXC_ILLEGAL_DATA, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET
   } exc_src_e;
   localparam int EXC_W = 12;
   typedef enum int unsigned {
      P_INT, P_MOD, P_IMISS, P_DMISS, P_IINV, P_DINV, P_IADR, P_DADR,
      P_SYS, P_BP, P_RI, P_OV, P_ERET
   } prio_e;
   localparam int PRIO_W = 13;
   localparam logic [4:0] C_INT = 5'd0, C_MOD = 5'd1, C_TLBL = 5'd2, C_TLBS = 5'd3;
   localparam logic [4:0] C_ADEL = 5'd4, C_ADES = 5'd5, C_SYS = 5'd8, C_BP = 5'd9;
   localparam logic [4:0] C_RI = 5'd10, C_OV = 5'd12;
   localparam logic [31:0] OFF_REFILL = 32'h000, OFF_GEN = 32'h180, OFF_IV = 32'h200;
   typedef enum logic [1:0] {BVA_NONE, BVA_INST, BVA_DATA} bva_sel_e;
   typedef enum logic {IDLE, FLUSH} state_e;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks the highest-priority exception and derives its code,
// vector offset and BadVAddr source; purely combinational.
module exc_prio_enc
   import exc_pkg::*;
#(
   parameter int NUM_INT     = 8,
   parameter int VEC_SPACING = 32
) (
   input  logic [EXC_W-1:0]   exc_vec,
   input  logic               data_we,
   input  logic [NUM_INT-1:0] int_pending,
   input  logic               allow_int,
   input  logic               exl_in,
   input  logic               bev,
   input  logic               iv,
   output logic [PRIO_W-1:0]  winner,
   output logic [4:0]         exc_code,
   output logic [31:0]        vec_off,
   output bva_sel_e           bva_sel,
   output logic               is_eret
);
   localparam int IW = NUM_INT > 1 ? $clog2(NUM_INT) : 1;
   logic [PRIO_W-1:0] req;
   logic [IW-1:0]     int_idx;
   logic              miss;
   assign req = {exc_vec[EXC_ERET], exc_vec[EXC_OV], exc_vec[EXC_RI], exc_vec[EXC_BP],
                 exc_vec[EXC_SYS], exc_vec[EXC_ILLEGAL_DATA], exc_vec[EXC_ILLEGAL_INST],
                 exc_vec[EXC_DATA_INVALID], exc_vec[EXC_INST_INVALID], exc_vec[EXC_DATA_MISS],
                 exc_vec[EXC_INST_MISS], exc_vec[EXC_DIRTY] & data_we, allow_int & (|int_pending)};
   // Isolate the lowest set request bit, which is the highest priority.
   assign winner  = req & (~req + PRIO_W'(1));
   assign is_eret = winner[P_ERET];
   assign miss    = winner[P_IMISS] | winner[P_DMISS];
   always_comb begin
      int_idx = '0;
      for (int i = 0; i < NUM_INT; i++)
         if (int_pending[i]) int_idx = IW'(i);
   end
   assign exc_code = winner[P_INT] ? C_INT :
                     winner[P_MOD] ? C_MOD :
                     (winner[P_IMISS] | winner[P_IINV]) ? C_TLBL :
                     (winner[P_DMISS] | winner[P_DINV]) ? (data_we ? C_TLBS : C_TLBL) :
                     winner[P_IADR] ? C_ADEL :
                     winner[P_DADR] ? (data_we ? C_ADES : C_ADEL) :
                     winner[P_SYS] ? C_SYS :
                     winner[P_BP] ? C_BP :
                     winner[P_RI] ? C_RI :
                     winner[P_OV] ? C_OV : 5'd0;
   assign vec_off = (winner[P_INT] & iv & ~bev) ? OFF_IV + (32'(int_idx) << $clog2(VEC_SPACING)) :
                    (miss & ~exl_in) ? OFF_REFILL : OFF_GEN;
   assign bva_sel = (winner[P_IMISS] | winner[P_IINV] | winner[P_IADR]) ? BVA_INST :
                    (winner[P_MOD] | winner[P_DMISS] | winner[P_DINV] | winner[P_DADR]) ? BVA_DATA :
                    BVA_NONE;
endmodule

// File: rtl/exception_ctrl_v2.sv
// exception_ctrl_v2: arbitrates MEM-stage exceptions, produces CP0 writes and a
// redirect target, and holds the pipeline flush until fetch has settled.
module exception_ctrl_v2
   import exc_pkg::*;
#(
   parameter int          NUM_INT     = 8,
   parameter int          FLUSH_PORTS = 4,
   parameter logic [31:0] RESET_EBASE = 32'hBFC00200,
   parameter int          VEC_SPACING = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [EXC_W-1:0]       exc_vec,
   input  logic [NUM_INT-1:0]     int_pending,
   input  logic                   allow_int,
   input  logic                   exl_in,
   input  logic                   bev,
   input  logic                   iv,
   input  logic [31:0]            ebase_in,
   input  logic [31:0]            epc_src,
   input  logic                   in_delayslot,
   input  logic [31:0]            pc_fetch,
   input  logic [31:0]            data_vaddr,
   input  logic                   data_we,
   input  logic [31:0]            epc_in,
   input  logic                   fetch_settled,
   output logic                   exc_pending,
   output logic [FLUSH_PORTS-1:0] flush,
   output logic                   wr_exp,
   output logic                   clear_exl,
   output logic [4:0]             exc_code,
   output logic [31:0]            epc_out,
   output logic                   bd_out,
   output logic [31:0]            badvaddr,
   output logic                   badvaddr_we,
   output logic [31:0]            new_pc
);
   state_e            state;
   logic [PRIO_W-1:0] winner;
   logic [4:0]        enc_code;
   logic [31:0]       vec_off, vec_base;
   bva_sel_e          bva_sel;
   logic              is_eret;
   exc_prio_enc #(.NUM_INT(NUM_INT), .VEC_SPACING(VEC_SPACING)) u_enc (
      .exc_vec(exc_vec), .data_we(data_we), .int_pending(int_pending), .allow_int(allow_int),
      .exl_in(exl_in), .bev(bev), .iv(iv), .winner(winner), .exc_code(enc_code),
      .vec_off(vec_off), .bva_sel(bva_sel), .is_eret(is_eret)
   );
   assign vec_base    = bev ? RESET_EBASE : ebase_in & 32'hFFFF_F000;
   // New requests are squashed while a flush is in flight.
   assign exc_pending = (state == IDLE) && (|winner);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         flush       <= '0;
         wr_exp      <= 1'b0;
         clear_exl   <= 1'b0;
         badvaddr_we <= 1'b0;
         bd_out      <= 1'b0;
         exc_code    <= '0;
         epc_out     <= '0;
         badvaddr    <= '0;
         new_pc      <= '0;
      end else begin
         wr_exp      <= 1'b0;
         clear_exl   <= 1'b0;
         badvaddr_we <= 1'b0;
         if (exc_pending) begin
            state     <= FLUSH;
            flush     <= '1;
            new_pc    <= is_eret ? epc_in : vec_base + vec_off;
            clear_exl <= is_eret;
            wr_exp    <= ~is_eret;
            if (!is_eret) begin
               exc_code <= enc_code;
               epc_out  <= in_delayslot ? epc_src - 32'd4 : epc_src;
               bd_out   <= in_delayslot;
            end
            if (bva_sel != BVA_NONE) begin
               badvaddr    <= bva_sel == BVA_INST ? pc_fetch : data_vaddr;
               badvaddr_we <= 1'b1;
            end
         end else if (state == FLUSH && fetch_settled) begin
            state <= IDLE;
            flush <= '0;
         end
      end
   end
endmodule

// File: tb/tb_exception_ctrl_v2.sv
// tb_exception_ctrl_v2: scoreboard bench; a first-match priority-list model
// predicts each accepted event and a monitor checks the DUT's strobed response.
module tb_exception_ctrl_v2;
   import exc_pkg::*;
   typedef struct packed {
      logic        eret;
      logic [4:0]  code;
      logic [31:0] epc;
      logic        bd;
      logic [31:0] bva;
      logic        bva_we;
      logic [31:0] pc;
   } txn_t;
   logic clk = 0, resetn = 0;
   logic [EXC_W-1:0] exc_vec = '0;
   logic [7:0] int_pending = '0;
   logic allow_int = 0, exl_in = 0, bev = 0, iv = 0, in_delayslot = 0, data_we = 0, fetch_settled = 0;
   logic [31:0] ebase_in = '0, epc_src = '0, pc_fetch = '0, data_vaddr = '0, epc_in = '0;
   logic exc_pending, wr_exp, clear_exl, bd_out, badvaddr_we;
   logic [3:0] flush;
   logic [4:0] exc_code;
   logic [31:0] epc_out, badvaddr, new_pc;
   int n_chk = 0, n_fail = 0;
   logic m_busy = 0;
   txn_t sbq[$];
   exception_ctrl_v2 dut (
      .clk(clk), .resetn(resetn), .exc_vec(exc_vec), .int_pending(int_pending),
      .allow_int(allow_int), .exl_in(exl_in), .bev(bev), .iv(iv), .ebase_in(ebase_in),
      .epc_src(epc_src), .in_delayslot(in_delayslot), .pc_fetch(pc_fetch),
      .data_vaddr(data_vaddr), .data_we(data_we), .epc_in(epc_in),
      .fetch_settled(fetch_settled), .exc_pending(exc_pending), .flush(flush),
      .wr_exp(wr_exp), .clear_exl(clear_exl), .exc_code(exc_code), .epc_out(epc_out),
      .bd_out(bd_out), .badvaddr(badvaddr), .badvaddr_we(badvaddr_we), .new_pc(new_pc)
   );
   always #5 clk = ~clk;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   // Ordered list of requests, highest priority first; first hit wins.
   function automatic logic model(output txn_t t);
      logic [12:0] r;
      int w, hi;
      logic [31:0] base, off;
      t = '0;
      r[0]  = allow_int && int_pending != 0;
      r[1]  = exc_vec[EXC_DIRTY] && data_we;
      r[2]  = exc_vec[EXC_INST_MISS];
      r[3]  = exc_vec[EXC_DATA_MISS];
      r[4]  = exc_vec[EXC_INST_INVALID];
      r[5]  = exc_vec[EXC_DATA_INVALID];
      r[6]  = exc_vec[EXC_ILLEGAL_INST];
      r[7]  = exc_vec[EXC_ILLEGAL_DATA];
      r[8]  = exc_vec[EXC_SYS];
      r[9]  = exc_vec[EXC_BP];
      r[10] = exc_vec[EXC_RI];
      r[11] = exc_vec[EXC_OV];
      r[12] = exc_vec[EXC_ERET];
      w = -1;
      for (int i = 12; i >= 0; i--) if (r[i]) w = i;
      if (w < 0) return 1'b0;
      if (w == 12) begin
         t.eret = 1;
         t.pc = epc_in;
         return 1'b1;
      end
      case (w)
         0: t.code = 0;
         1: t.code = 1;
         2, 4: t.code = 2;
         3, 5: t.code = data_we ? 3 : 2;
         6: t.code = 4;
         7: t.code = data_we ? 5 : 4;
         8: t.code = 8;
         9: t.code = 9;
         10: t.code = 10;
         default: t.code = 12;
      endcase
      t.epc = in_delayslot ? epc_src - 4 : epc_src;
      t.bd = in_delayslot;
      t.bva_we = (w >= 1 && w <= 7);
      t.bva = (w == 2 || w == 4 || w == 6) ? pc_fetch : (t.bva_we ? data_vaddr : 32'h0);
      hi = 0;
      for (int i = 0; i < 8; i++) if (int_pending[i]) hi = i;
      base = bev ? 32'hBFC00200 : {ebase_in[31:12], 12'h000};
      if (w == 0 && iv && !bev) off = 32'h200 + 32 * hi;
      else if ((w == 2 || w == 3) && !exl_in) off = 32'h000;
      else off = 32'h180;
      t.pc = base + off;
      return 1'b1;
   endfunction
   task automatic step();
      txn_t t;
      logic q;
      #1;
      q = !m_busy && model(t);
      chk("exc_pending", {31'b0, exc_pending}, {31'b0, q});
      if (q) sbq.push_back(t);
      @(posedge clk);
      if (q) m_busy = 1;
      else if (m_busy && fetch_settled) m_busy = 0;
      @(negedge clk);
   endtask
   task automatic settle();
      exc_vec = '0;
      allow_int = 0;
      int_pending = '0;
      fetch_settled = 1;
      step();
      step();
   endtask
   always begin
      txn_t t;
      @(posedge clk);
      #1;
      if (resetn) begin
         chk("flush", {28'b0, flush}, {28'b0, {4{m_busy}}});
         if (sbq.size() != 0) begin
            t = sbq.pop_front();
            chk("wr_exp", {31'b0, wr_exp}, {31'b0, ~t.eret});
            chk("clear_exl", {31'b0, clear_exl}, {31'b0, t.eret});
            chk("badvaddr_we", {31'b0, badvaddr_we}, {31'b0, t.bva_we});
            chk("new_pc", new_pc, t.pc);
            if (!t.eret) begin
               chk("exc_code", {27'b0, exc_code}, {27'b0, t.code});
               chk("epc_out", epc_out, t.epc);
               chk("bd_out", {31'b0, bd_out}, {31'b0, t.bd});
            end
            if (t.bva_we) chk("badvaddr", badvaddr, t.bva);
         end else
            chk("idle_strobes", {29'b0, wr_exp, clear_exl, badvaddr_we}, 32'h0);
      end
   end
   initial begin
      #1;
      chk("rst_flush", {28'b0, flush}, 32'h0);
      chk("rst_strobes", {29'b0, wr_exp, clear_exl, badvaddr_we}, 32'h0);
      chk("rst_code_bd", {26'b0, exc_code, bd_out}, 32'h0);
      chk("rst_epc", epc_out, 32'h0);
      chk("rst_newpc", new_pc, 32'h0);
      chk("rst_badvaddr", badvaddr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1;
      bev = 1;
      exc_vec[EXC_SYS] = 1;
      epc_src = 32'h8000_0100;
      step();
      chk("tp_sys_code", {27'b0, exc_code}, 32'd8);
      chk("tp_sys_newpc", new_pc, 32'hBFC0_0380);
      chk("tp_sys_epc", epc_out, 32'h8000_0100);
      chk("tp_sys_flush", {28'b0, flush}, 32'hF);
      settle();
      bev = 0;
      ebase_in = 32'h8000_0000;
      pc_fetch = 32'h0040_1000;
      exc_vec[EXC_INST_MISS] = 1;
      step();
      chk("tp_imiss_newpc", new_pc, 32'h8000_0000);
      chk("tp_imiss_bva", badvaddr, 32'h0040_1000);
      settle();
      exl_in = 1;
      exc_vec[EXC_INST_MISS] = 1;
      step();
      chk("tp_imiss_exl_newpc", new_pc, 32'h8000_0180);
      settle();
      exl_in = 0;
      iv = 1;
      allow_int = 1;
      int_pending = 8'b0010_0100;
      step();
      chk("tp_int_code", {27'b0, exc_code}, 32'd0);
      chk("tp_int_newpc", new_pc, 32'h8000_02A0);
      settle();
      in_delayslot = 1;
      epc_src = 32'h8000_0204;
      exc_vec[EXC_OV] = 1;
      step();
      chk("tp_ov_epc", epc_out, 32'h8000_0200);
      chk("tp_ov_bd", {31'b0, bd_out}, 32'd1);
      settle();
      in_delayslot = 0;
      exc_vec[EXC_OV] = 1;
      exc_vec[EXC_RI] = 1;
      exc_vec[EXC_BP] = 1;
      step();
      chk("tp_multi_code", {27'b0, exc_code}, 32'd9);
      settle();
      epc_in = 32'h8000_1234;
      exc_vec[EXC_ERET] = 1;
      step();
      chk("tp_eret_newpc", new_pc, 32'h8000_1234);
      chk("tp_eret_code_kept", {27'b0, exc_code}, 32'd9);
      exc_vec = '0;
      exc_vec[EXC_SYS] = 1;
      fetch_settled = 0;
      repeat (5) step();
      chk("tp_flush_held", {28'b0, flush}, 32'hF);
      fetch_settled = 1;
      step();
      chk("tp_flush_drop", {28'b0, flush}, 32'h0);
      step();
      settle();
      exc_vec[EXC_SYS] = 1;
      fetch_settled = 0;
      step();
      step();
      resetn = 0;
      #1;
      chk("tp_rst_flush", {28'b0, flush}, 32'h0);
      chk("tp_rst_strobes", {29'b0, wr_exp, clear_exl, badvaddr_we}, 32'h0);
      m_busy = 0;
      exc_vec = '0;
      @(negedge clk);
      resetn = 1;
      step();
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 3))
            0: exc_vec = EXC_W'($urandom);
            1, 2: exc_vec = EXC_W'(1) << $urandom_range(0, EXC_W - 1);
            default: exc_vec = '0;
         endcase
         int_pending = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
         allow_int = 1'($urandom);
         exl_in = 1'($urandom);
         bev = 1'($urandom);
         iv = 1'($urandom);
         data_we = 1'($urandom);
         in_delayslot = 1'($urandom);
         fetch_settled = 1'($urandom);
         ebase_in = $urandom;
         epc_src = $urandom;
         pc_fetch = $urandom;
         data_vaddr = $urandom;
         epc_in = $urandom;
         step();
      end
      settle();
      chk("sb_empty", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
